// File: rtl/sonar_sweep_ranger.sv
// Servo-swept ultrasonic ranger: step servo, settle, trigger, time the echo, convert it to cm.
// Define MIN_TRACK_EN to build per-sweep minimum distance tracking (min_cm/min_pos).
//
// state     | meaning
// IDLE      | parked, waiting for en
// SETTLE    | servo settling, SETTLE_US ticks
// TRIG      | trigger high, TRIG_US ticks
// WAIT_RISE | waiting for echo 0->1, TIMEOUT_US ticks max
// WAIT_FALL | counting echo-high ticks
// DIVIDE    | ticks / 58 by repeated subtraction
// REPORT    | publish result, step servo
module sonar_sweep_ranger #(
  parameter int CLK_HZ     = 27_000_000,
  parameter int TICK_HZ    = 1_000_000,
  parameter int TRIG_US    = 10,
  parameter int SETTLE_US  = 60_000,
  parameter int TIMEOUT_US = 30_000,
  parameter int POS_MIN    = 60,
  parameter int POS_MAX    = 230,
  parameter int POS_STEP   = 1,
  parameter int CNT_W      = 16,
  parameter int DIST_W     = 10,
  parameter int NEAR_CM    = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              hold,
  input  logic              echo,
  output logic              trigger,
  output logic [7:0]        servo_pos,
  output logic              dir,
  output logic [DIST_W-1:0] dist_cm,
  output logic [7:0]        dist_pos,
  output logic              dist_valid,
  output logic              timeout,
  output logic              near,
  output logic              busy,
  output logic [DIST_W-1:0] min_cm,
  output logic [7:0]        min_pos
);

  localparam int DIV        = CLK_HZ / TICK_HZ;
  localparam int DIV_W      = $clog2(DIV);
  localparam int TMR_MAX    = (SETTLE_US > TIMEOUT_US) ?
                              ((SETTLE_US > TRIG_US) ? SETTLE_US : TRIG_US) :
                              ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US);
  localparam int TMR_W      = $clog2(TMR_MAX + 1);
  localparam int DIST_MAX_I = (2 ** DIST_W) - 1;
  localparam logic [CNT_W-1:0] CM_TICKS = CNT_W'(58);
  localparam logic [7:0] P_MIN  = 8'(POS_MIN);
  localparam logic [7:0] P_MAX  = 8'(POS_MAX);
  localparam logic [7:0] P_STEP = 8'(POS_STEP);

  typedef enum logic [2:0] {
    IDLE, SETTLE, TRIG, WAIT_RISE, WAIT_FALL, DIVIDE, REPORT
  } state_t;

  state_t state, state_next;

  logic              echo_m, echo_s, echo_d, rise;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [TMR_W-1:0]  tmr;
  logic              tmr_done;
  logic [CNT_W-1:0]  cnt, rem, quo;
  logic              cnt_stop;
  logic [DIST_W-1:0] quo_sat;
  logic              quo_near;
  logic [7:0]        pos_step;
  logic              dir_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) {echo_m, echo_s, echo_d} <= '0;
    else     {echo_m, echo_s, echo_d} <= {echo, echo_m, echo_s};
  end
  assign rise = echo_s & ~echo_d;

  assign tick = (div_cnt == '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= DIV_W'(DIV - 1);
    else           div_cnt <= div_cnt - DIV_W'(1);
  end

  assign tmr_done = tick && (tmr == TMR_W'(1));
  assign cnt_stop = tick && ((cnt == '1) || (32'(cnt) + 32'd1 >= 32'(TIMEOUT_US)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (en) state_next = SETTLE;
      SETTLE:    if (tmr_done) state_next = TRIG;
      TRIG:      if (tmr_done) state_next = WAIT_RISE;
      WAIT_RISE: if (rise) state_next = WAIT_FALL;
                 else if (tmr_done) state_next = REPORT;
      WAIT_FALL: if (!echo_s) state_next = DIVIDE;
                 else if (cnt_stop) state_next = REPORT;
      DIVIDE:    if (rem < CM_TICKS) state_next = REPORT;
      REPORT:    state_next = en ? SETTLE : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign trigger    = (state == TRIG);
  assign dist_valid = (state == REPORT);
  assign busy       = (state != IDLE);

  assign quo_sat  = (32'(quo) > DIST_MAX_I) ? '1 : DIST_W'(quo);
  assign quo_near = (32'(quo_sat) < NEAR_CM);

  // Reflect off the limits; the reversal step moves away from the limit in the same report.
  always_comb begin
    pos_step = servo_pos;
    dir_step = dir;
    if (!dir) begin
      if (9'(servo_pos) + 9'(P_STEP) > 9'(P_MAX)) begin
        dir_step = 1'b1;
        pos_step = servo_pos - P_STEP;
      end else begin
        pos_step = servo_pos + P_STEP;
      end
    end else begin
      if (9'(servo_pos) < 9'(P_MIN) + 9'(P_STEP)) begin
        dir_step = 1'b0;
        pos_step = servo_pos + P_STEP;
      end else begin
        pos_step = servo_pos - P_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr       <= '0;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      servo_pos <= P_MIN;
      dir       <= 1'b0;
      dist_cm   <= '0;
      dist_pos  <= '0;
      timeout   <= 1'b0;
      near      <= 1'b0;
    end else begin
      if (state_next != state) begin
        case (state_next)
          SETTLE:    tmr <= TMR_W'(SETTLE_US);
          TRIG:      tmr <= TMR_W'(TRIG_US);
          WAIT_RISE: tmr <= TMR_W'(TIMEOUT_US);
          default:   tmr <= tmr;
        endcase
      end else if (tick && tmr != '0) begin
        tmr <= tmr - TMR_W'(1);
      end

      // The rise cycle counts its own tick so the count matches the echo width exactly.
      if (state == WAIT_RISE && rise)
        cnt <= tick ? CNT_W'(1) : '0;
      else if (state == WAIT_FALL && tick && cnt != '1)
        cnt <= cnt + CNT_W'(1);

      if (state == WAIT_FALL && state_next == DIVIDE) begin
        rem <= cnt;
        quo <= '0;
      end else if (state == DIVIDE && rem >= CM_TICKS) begin
        rem <= rem - CM_TICKS;
        quo <= quo + CNT_W'(1);
      end

      if (state_next == REPORT && state != REPORT) begin
        dist_pos <= servo_pos;
        if (state == DIVIDE) begin
          dist_cm <= quo_sat;
          timeout <= 1'b0;
          near    <= quo_near;
        end else begin
          dist_cm <= '1;
          timeout <= 1'b1;
          near    <= 1'b0;
        end
      end

      if (state == REPORT && !hold) begin
        servo_pos <= pos_step;
        dir       <= dir_step;
      end
    end
  end

`ifdef MIN_TRACK_EN
  logic [DIST_W-1:0] run_cm, cand_cm;
  logic [7:0]        run_pos, cand_pos;
  logic              sweep_end;

  assign sweep_end = !hold && (dir_step != dir);

  // Strict compare keeps the first position on ties.
  always_comb begin
    cand_cm  = run_cm;
    cand_pos = run_pos;
    if (!timeout && dist_cm < run_cm) begin
      cand_cm  = dist_cm;
      cand_pos = dist_pos;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cm  <= '1;
      run_pos <= '0;
      min_cm  <= '1;
      min_pos <= '0;
    end else if (state == REPORT) begin
      if (sweep_end) begin
        min_cm  <= cand_cm;
        min_pos <= cand_pos;
        run_cm  <= '1;
        run_pos <= '0;
      end else begin
        run_cm  <= cand_cm;
        run_pos <= cand_pos;
      end
    end
  end
`else
  assign min_cm  = '1;
  assign min_pos = '0;
`endif

endmodule

// File: tb/tb_sonar_sweep_ranger.sv
// Directed bench for sonar_sweep_ranger with shortened timing (3 clk per tick).
module tb_sonar_sweep_ranger;

  localparam int DIV        = 3;
  localparam int TRIG_US    = 4;
  localparam int SETTLE_US  = 20;
  localparam int TIMEOUT_US = 6000;
  localparam int DIST_W     = 10;

  logic              clk = 1'b0;
  logic              rst, en, hold, echo;
  logic              trigger, dir, dist_valid, timeout, near, busy;
  logic [7:0]        servo_pos, dist_pos, min_pos;
  logic [DIST_W-1:0] dist_cm, min_cm;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_wait;
  int t7, t8, t9;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sonar_sweep_ranger #(
    .CLK_HZ(DIV), .TICK_HZ(1), .TRIG_US(TRIG_US), .SETTLE_US(SETTLE_US),
    .TIMEOUT_US(TIMEOUT_US), .POS_MIN(60), .POS_MAX(62), .POS_STEP(1),
    .CNT_W(16), .DIST_W(DIST_W), .NEAR_CM(100)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .hold(hold), .echo(echo),
    .trigger(trigger), .servo_pos(servo_pos), .dir(dir),
    .dist_cm(dist_cm), .dist_pos(dist_pos), .dist_valid(dist_valid),
    .timeout(timeout), .near(near), .busy(busy),
    .min_cm(min_cm), .min_pos(min_pos)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_trigger"},    trigger, 0);
    check({pfx, "_servo_pos"},  servo_pos, 60);
    check({pfx, "_dir"},        dir, 0);
    check({pfx, "_dist_cm"},    dist_cm, 0);
    check({pfx, "_dist_pos"},   dist_pos, 0);
    check({pfx, "_dist_valid"}, dist_valid, 0);
    check({pfx, "_timeout"},    timeout, 0);
    check({pfx, "_near"},       near, 0);
    check({pfx, "_busy"},       busy, 0);
    check({pfx, "_min_cm"},     min_cm, 1023);
    check({pfx, "_min_pos"},    min_pos, 0);
  endtask

  // mode 0: normal, 1: drop en mid-echo, 2: reset mid-echo, 3: echo already high during trigger
  task automatic do_ping(input int ticks, input int mode);
    int n, w;
    n = 0;
    while (!trigger && n < 200) begin @(negedge clk); n++; end
    check("trig_rise", trigger, 1);
    w = 0;
    while (trigger && w < 100) begin
      if (mode == 3 && w == 0) echo = 1'b1;
      @(negedge clk);
      w++;
    end
    check("trig_width", w, TRIG_US * DIV);
    if (mode == 3) begin
      repeat (60) @(negedge clk);
      echo = 1'b0;
    end
    if (ticks > 0) begin
      repeat (5) @(negedge clk);
      echo = 1'b1;
      for (int i = 0; i < ticks * DIV; i++) begin
        if (i == (ticks * DIV) / 2) begin
          if (mode == 1) en = 1'b0;
          if (mode == 2) begin
            #2 rst = 1'b1;
            #1 check_reset_vals("mid_rst");
          end
        end
        @(negedge clk);
      end
      echo = 1'b0;
    end
  endtask

  task automatic wait_result(input int exp_dist, input int exp_pos, input int exp_to,
                             input int exp_near, input int exp_next_pos, input int exp_next_dir,
                             output int at_cyc);
    int n;
    n = 0;
    while (!dist_valid && n < 25000) begin @(negedge clk); n++; end
    check("valid_seen", dist_valid, 1);
    last_wait = n;
    at_cyc = cyc;
    check("dist_cm", dist_cm, exp_dist);
    check("dist_pos", dist_pos, exp_pos);
    check("timeout", timeout, exp_to);
    check("near", near, exp_near);
    check("servo_at_valid", servo_pos, exp_pos);
    @(negedge clk);
    check("valid_pulse", dist_valid, 0);
    check("servo_next", servo_pos, exp_next_pos);
    check("dir_next", dir, exp_next_dir);
  endtask

  initial begin
    int n, t;
    rst = 1'b1; en = 1'b0; hold = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_trigger", trigger, 0);

    // P1 @60: no echo -> timeout exactly TIMEOUT_US ticks after trigger falls
    en = 1'b1;
    n = 0;
    while (!trigger && n < 200) begin @(negedge clk); n++; end
    check("settle_len", (n >= 59 && n <= 61), 1);
    check("busy_run", busy, 1);
    do_ping(0, 0);
    wait_result(1023, 60, 1, 0, 61, 0, t);
    check("timeout_len", last_wait, TIMEOUT_US * DIV);

    // P2 @61: 580 ticks -> 10 cm
    do_ping(580, 0);
    wait_result(10, 61, 0, 1, 62, 0, t);

    // P3 @62: 579 ticks -> 9 cm, reversal at top
    do_ping(579, 0);
    wait_result(9, 62, 0, 1, 61, 1, t);
`ifdef MIN_TRACK_EN
    check("min_cm_up", min_cm, 9);
    check("min_pos_up", min_pos, 62);
`else
    check("min_cm_const", min_cm, 1023);
    check("min_pos_const", min_pos, 0);
`endif

    // P4 @61: 5800 ticks -> 100 cm, not near
    do_ping(5800, 0);
    wait_result(100, 61, 0, 0, 60, 1, t);

    // P5 @60: 5742 ticks -> 99 cm, reversal at bottom
    do_ping(5742, 0);
    wait_result(99, 60, 0, 1, 61, 0, t);
`ifdef MIN_TRACK_EN
    check("min_cm_down", min_cm, 99);
    check("min_pos_down", min_pos, 60);
`else
    check("min_cm_const2", min_cm, 1023);
`endif

    // P6 @61: echo high during trigger is ignored; later 115 ticks -> 1 cm
    do_ping(115, 3);
    wait_result(1, 61, 0, 1, 62, 0, t);

    // P7..P9 hold at 62; en dropped mid-echo on P9
    hold = 1'b1;
    do_ping(58, 0);
    wait_result(1, 62, 0, 1, 62, 0, t7);
    do_ping(58, 0);
    wait_result(1, 62, 0, 1, 62, 0, t8);
    do_ping(58, 1);
    wait_result(1, 62, 0, 1, 62, 0, t9);
    check("hold_gap1", (t8 - t7) >= (SETTLE_US + TRIG_US) * DIV, 1);
    check("hold_gap2", (t9 - t8) >= (SETTLE_US + TRIG_US) * DIV, 1);
    check("en_off_busy", busy, 0);
    repeat (30) @(negedge clk);
    check("parked_busy", busy, 0);
    check("parked_trigger", trigger, 0);

    // P10 @62: reset asserted mid-echo
    hold = 1'b0;
    en = 1'b1;
    do_ping(300, 2);
    echo = 1'b0;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_servo", servo_pos, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
